// File: rtl/riscv_fetch.sv
// riscv_fetch: single-outstanding instruction fetch FSM (REQ/WAIT/HOLD) with redirect and drop handling.
// Optional misaligned-redirect detection is enabled by defining RISCV_FETCH_ALIGN_CHECK_EN.
module riscv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
  output logic        fetch_misalign,
`endif
  input  logic        inst_ready
);
  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;
  state_t      state;
  logic [31:0] pc;
  logic [31:0] rpc;
  logic        drop;
  logic        misal;
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
  assign rpc            = redirect_pc;
  assign misal          = pc[1:0] != 2'b00;
  assign fetch_misalign = inst_valid && misal;
`else
  assign rpc   = redirect_pc & ~32'h3;
  assign misal = 1'b0;
`endif
  assign imem_req   = state == REQ && !misal;
  assign imem_addr  = pc;
  assign inst_valid = state == HOLD;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= REQ;
      pc      <= RESET_PC;
      drop    <= 1'b0;
      inst    <= 32'h0;
      inst_pc <= 32'h0;
    end else begin
      case (state)
        REQ: begin
          if (redirect_valid) begin
            pc <= rpc;
            if (imem_req && imem_ready) begin
              state <= WAIT;
              drop  <= 1'b1;
            end
          end else if (misal) begin
            state   <= HOLD;
            inst    <= 32'h0000_0013;
            inst_pc <= pc;
          end else if (imem_ready) state <= WAIT;
        end
        WAIT: begin
          if (redirect_valid) pc <= rpc;
          if (imem_rvalid && !drop && !redirect_valid) begin
            inst    <= imem_rdata;
            inst_pc <= pc;
            pc      <= pc + 32'd4;
            state   <= HOLD;
          end else if (imem_rvalid) begin
            state <= REQ;
            drop  <= 1'b0;
          end else if (redirect_valid) drop <= 1'b1;
        end
        HOLD: begin
          if (redirect_valid) pc <= rpc;
          if (inst_ready || redirect_valid) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_fetch.sv
// tb_riscv_fetch: scoreboard bench for riscv_fetch with a simple memory responder.
module tb_riscv_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign;
`endif
  logic [31:0] acc_addr = 32'h0;
  logic [31:0] ovr = 32'h0;
  logic        use_ovr = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          fire_cyc = 0;
  int          prev_cyc = 0;
  typedef struct {logic [31:0] pc; logic [31:0] data;} exp_t;
  exp_t q[$];

  riscv_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
    .fetch_misalign(fetch_misalign),
`endif
    .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_req && imem_ready) acc_addr <= imem_addr;
  end
  assign imem_rdata = use_ovr ? ovr : mem_word(acc_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    q.push_back('{a, mem_word(a)});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {imem_ready, imem_rvalid, redirect_valid, inst_ready, use_ovr} = '0;
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_fire(input string tag);
    exp_t e;
    int   n = 0;
    while (!(inst_valid && inst_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk({tag, " timeout"}, {31'b0, inst_valid && inst_ready}, 32'd1);
    else if (q.size() == 0) chk({tag, " unexpected"}, inst_pc, 32'hFFFF_FFFF);
    else begin
      e = q.pop_front();
      chk({tag, " pc"}, inst_pc, e.pc);
      chk({tag, " inst"}, inst, e.data);
      prev_cyc = fire_cyc;
      fire_cyc = cyc;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state and first request
    @(negedge clk);
    chk("rst inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst inst", inst, 32'h0);
    chk("rst inst_pc", inst_pc, 32'h0);
    do_reset();
    chk("rel req", {31'b0, imem_req}, 32'd1);
    chk("rel addr", imem_addr, 32'h0);
    // zero-latency streaming, one instruction per 3 cycles
    {imem_ready, imem_rvalid, inst_ready} = 3'b111;
    push(32'h0); push(32'h4); push(32'h8);
    wait_fire("t1 f0");
    wait_fire("t1 f1");
    chk("t1 spacing1", fire_cyc - prev_cyc, 32'd3);
    wait_fire("t1 f2");
    chk("t1 spacing2", fire_cyc - prev_cyc, 32'd3);
    // stall in HOLD; rvalid held high must be ignored
    do_reset();
    {imem_ready, imem_rvalid} = 2'b11;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall valid", {31'b0, inst_valid}, 32'd1);
      chk("stall req", {31'b0, imem_req}, 32'd0);
      chk("stall pc", inst_pc, 32'h0);
      chk("stall inst", inst, mem_word(32'h0));
      @(negedge clk);
    end
    push(32'h0);
    inst_ready = 1'b1;
    wait_fire("stall fire");
    // redirect in WAIT drops the in-flight response
    do_reset();
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_rvalid = 1'b1; use_ovr = 1'b1; ovr = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("drop valid", {31'b0, inst_valid}, 32'd0);
    chk("drop req", {31'b0, imem_req}, 32'd1);
    chk("drop addr", imem_addr, 32'h100);
    use_ovr = 1'b0; imem_ready = 1'b1; inst_ready = 1'b1;
    push(32'h100);
    wait_fire("drop next");
    // redirect together with imem_ready in REQ
    do_reset();
    imem_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0; imem_ready = 1'b0;
    imem_rvalid = 1'b1; use_ovr = 1'b1; ovr = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rdyredir valid", {31'b0, inst_valid}, 32'd0);
    chk("rdyredir addr", imem_addr, 32'h200);
    use_ovr = 1'b0; imem_ready = 1'b1; inst_ready = 1'b1;
    push(32'h200);
    wait_fire("rdyredir next");
    // redirect in HOLD, then redirect coincident with a fire
    do_reset();
    {imem_ready, imem_rvalid} = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("hold valid", {31'b0, inst_valid}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("hredir valid", {31'b0, inst_valid}, 32'd0);
    chk("hredir addr", imem_addr, 32'h300);
    @(negedge clk);
    @(negedge clk);
    push(32'h300);
    inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    wait_fire("fire+redir");
    redirect_valid = 1'b0;
    chk("fire+redir addr", imem_addr, 32'h400);
    // pc wraps from the top of the address space
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("wrap addr0", imem_addr, 32'hFFFF_FFFC);
    {imem_ready, imem_rvalid, inst_ready} = 3'b111;
    push(32'hFFFF_FFFC); push(32'h0);
    wait_fire("wrap f0");
    chk("wrap addr1", imem_addr, 32'h0);
    wait_fire("wrap f1");
    // reset mid-WAIT, late rvalid after release
    do_reset();
    {imem_ready, imem_rvalid, inst_ready} = 3'b111;
    push(32'h0); push(32'h4);
    wait_fire("mr f0");
    wait_fire("mr f1");
    imem_rvalid = 1'b0;
    @(negedge clk);
    imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async valid", {31'b0, inst_valid}, 32'd0);
    chk("async inst", inst, 32'h0);
    chk("async inst_pc", inst_pc, 32'h0);
    chk("async addr", imem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    imem_rvalid = 1'b1; use_ovr = 1'b1; ovr = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late valid", {31'b0, inst_valid}, 32'd0);
      chk("late addr", imem_addr, 32'h0);
    end
    imem_rvalid = 1'b0; use_ovr = 1'b0;
    // misaligned redirect
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
    chk("mis req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    chk("mis valid", {31'b0, inst_valid}, 32'd1);
    chk("mis flag", {31'b0, fetch_misalign}, 32'd1);
    chk("mis inst", inst, 32'h0000_0013);
    chk("mis pc", inst_pc, 32'h102);
    chk("mis hold req", {31'b0, imem_req}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("mis clr", {31'b0, fetch_misalign}, 32'd0);
`endif
    chk("align addr", imem_addr, 32'h100);
    {imem_ready, imem_rvalid, inst_ready} = 3'b111;
    push(32'h100);
    wait_fire("align fetch");
    chk("queue empty", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
